// File: rtl/uart_dma_pkg.sv
// Shared widths and state encoding for the UART DMA datapath blocks.
package uart_dma_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int TIMEOUT_W   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // NOTE: grant gets its default before the loop, so no path leaves it unassigned and no latch forms.
    always_comb begin
        grant = '0;
        // Walk offsets from the far end so the requester closest to ptr is the final writer.
        for (int i = N - 1; i >= 0; i--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && ((int'(ptr) + i) % N) == j) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART tx byte path among NUM_REQ sources.
module uart_tx_arbiter
    import uart_dma_pkg::*;
#(
    parameter int                   NUM_REQ     = 2,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [UART_BYTE_W-1:0]         o_uart_tx_data,
    output logic                           o_uart_tx_valid,
    input  logic                           i_uart_tx_ready,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d, gidx_q, gidx_d, arb_idx, ptr_next;
    logic [UART_BYTE_W-1:0] data_q, data_d, g_data;
    logic                   valid_q, valid_d, tout_q, tout_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     arb_grant;
    logic                   g_valid, g_last, slot_free, hs;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req   (i_req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        o_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) arb_idx = PTR_W'(k);
            o_grant[k] = (state_q == ST_XFER) && (gidx_q == PTR_W'(k));
            if (gidx_q == PTR_W'(k)) begin
                g_valid = i_req_valid[k];
                g_last  = i_req_last[k];
                g_data  = i_req_data[k*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    assign slot_free   = !valid_q || i_uart_tx_ready;
    assign o_req_ready = slot_free ? o_grant : '0;
    assign hs          = (state_q == ST_XFER) && g_valid && slot_free;
    // The finishing owner hands first priority to its neighbour.
    assign ptr_next    = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;

        if (valid_q && i_uart_tx_ready) valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|i_req_valid) begin
                    state_d = ST_XFER;
                    gidx_d  = arb_idx;
                end
            end
            ST_XFER: begin
                if (hs) begin
                    data_d  = g_data;
                    valid_d = 1'b1;
                end
                if (g_valid) begin
                    cnt_d = '0;
                    if (hs && g_last) begin
                        state_d = ST_IDLE;
                        ptr_d   = ptr_next;
                    end
                end else if (TIMEOUT_CYC != '0 && cnt_q == TIMEOUT_CYC - 16'd1) begin
                    // Stalled owner: release it, but the byte already held still drains.
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                end else if (TIMEOUT_CYC != '0) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign o_uart_tx_data  = data_q;
    assign o_uart_tx_valid = valid_q;
    assign o_busy          = (state_q == ST_XFER) || valid_q;
    assign o_timeout       = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a 2-requester instance with an 8-cycle timeout and a 4-requester instance with it disabled.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_data;
    logic [1:0]  a_valid, a_last, a_ready, a_grant;
    logic [7:0]  a_tx_data;
    logic        a_tx_valid, a_uart_ready, a_busy, a_tout;

    logic [31:0] b_data;
    logic [3:0]  b_valid, b_last, b_ready, b_grant;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid, b_uart_ready, b_busy, b_tout;

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(16'd8)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_req_data(a_data), .i_req_valid(a_valid), .i_req_last(a_last), .o_req_ready(a_ready),
        .o_uart_tx_data(a_tx_data), .o_uart_tx_valid(a_tx_valid), .i_uart_tx_ready(a_uart_ready),
        .o_grant(a_grant), .o_busy(a_busy), .o_timeout(a_tout)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16'd0)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_req_data(b_data), .i_req_valid(b_valid), .i_req_last(b_last), .o_req_ready(b_ready),
        .o_uart_tx_data(b_tx_data), .o_uart_tx_valid(b_tx_valid), .i_uart_tx_ready(b_uart_ready),
        .o_grant(b_grant), .o_busy(b_busy), .o_timeout(b_tout)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc, drop_cyc, tout_cyc, tout_n;
    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [3:0] rdy_pat;
    logic [1:0] prev_grant;
    int tx_log[16], tx_cyc[16], tx_n;
    int own_log[16], own_cyc[16], own_n;
    int hs_id[16], hs_cyc[16], hs_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_sources();
        a_valid = '0;
        a_last  = '0;
        a_data  = '0;
        if (src0.size() != 0) begin
            a_valid[0]   = 1'b1;
            a_last[0]    = src0[0][8];
            a_data[7:0]  = src0[0][7:0];
        end
        if (src1.size() != 0) begin
            a_valid[1]   = 1'b1;
            a_last[1]    = src1[0][8];
            a_data[15:8] = src1[0][7:0];
        end
        a_uart_ready = rdy_pat[2'(cyc)];
    endtask

    task automatic run_cycle();
        logic [1:0] hs;
        logic       stall;
        logic [7:0] held;
        hs = a_valid & a_ready;
        check("ready_only_granted", 32'(a_ready & ~a_grant), 32'd0);
        check("grant_onehot0", 32'($onehot0(a_grant)), 32'd1);
        for (int i = 0; i < 2; i++) begin
            if (hs[i] && hs_n < 16) begin
                hs_id[hs_n] = i;
                hs_cyc[hs_n] = cyc;
                hs_n++;
            end
        end
        if (a_tx_valid && a_uart_ready && tx_n < 16) begin
            tx_log[tx_n] = int'(a_tx_data);
            tx_cyc[tx_n] = cyc;
            tx_n++;
        end
        if (a_grant != 2'b00 && a_grant != prev_grant && own_n < 16) begin
            own_log[own_n] = a_grant[1] ? 1 : 0;
            own_cyc[own_n] = cyc;
            own_n++;
        end
        prev_grant = a_grant;
        if (a_tout) begin
            tout_n++;
            tout_cyc = cyc;
        end
        stall = a_tx_valid && !a_uart_ready;
        held  = a_tx_data;
        @(posedge clk);
        #1;
        cyc++;
        if (hs[0]) begin
            void'(src0.pop_front());
            if (src0.size() == 0) drop_cyc = cyc;
        end
        if (hs[1]) void'(src1.pop_front());
        apply_sources();
        #2;
        if (stall) begin
            check("stall_hold_valid", 32'(a_tx_valid), 32'd1);
            check("stall_hold_data", 32'(a_tx_data), 32'(held));
        end
    endtask

    task automatic do_reset();
        src0.delete();
        src1.delete();
        for (int i = 0; i < 16; i++) begin
            tx_log[i] = -1; tx_cyc[i] = -1; own_log[i] = -1; own_cyc[i] = -1; hs_id[i] = -1; hs_cyc[i] = -1;
        end
        tx_n = 0; own_n = 0; hs_n = 0;
        tout_n = 0; tout_cyc = -100; drop_cyc = -100; cyc = 0;
        prev_grant = '0;
        rdy_pat = 4'hF;
        rst = 1'b1;
        a_valid = '0; a_last = '0; a_data = '0; a_uart_ready = 1'b1;
        b_valid = '0; b_last = '0; b_data = '0; b_uart_ready = 1'b1;
        @(posedge clk);
        #3;
        check("rst_tx_valid", 32'(a_tx_valid), 32'd0);
        check("rst_tx_data", 32'(a_tx_data), 32'h00);
        check("rst_grant", 32'(a_grant), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_timeout", 32'(a_tout), 32'd0);
        check("rst_b_grant", 32'(b_grant), 32'd0);
        check("rst_b_tx_valid", 32'(b_tx_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        cyc = 0;
        apply_sources();
        #2;
    endtask

    int  bseq[16];
    int  bbytes[16];
    int  nb, nby, b_touts;
    logic [3:0] b_prev;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        // 1: single 3-byte frame from req0 at full rate.
        do_reset();
        src0 = '{9'h0A1, 9'h0A2, 9'h1A3};
        release_rst();
        check("t1_idle_grant", 32'(a_grant), 32'd0);
        check("t1_idle_ready", 32'(a_ready), 32'd0);
        repeat (8) run_cycle();
        check("t1_tx_count", 32'(tx_n), 32'd3);
        check("t1_byte0", 32'(tx_log[0]), 32'h0A1);
        check("t1_byte1", 32'(tx_log[1]), 32'h0A2);
        check("t1_byte2", 32'(tx_log[2]), 32'h0A3);
        check("t1_byte0_cyc", 32'(tx_cyc[0]), 32'd2);
        check("t1_byte2_cyc", 32'(tx_cyc[2]), 32'd4);
        check("t1_grant_cyc", 32'(own_cyc[0]), 32'd1);
        check("t1_owner", 32'(own_log[0]), 32'd0);
        check("t1_end_grant", 32'(a_grant), 32'd0);
        check("t1_end_busy", 32'(a_busy), 32'd0);

        // 2: both requesters ready at reset release; frames must not interleave.
        do_reset();
        src0 = '{9'h0B0, 9'h1B1};
        src1 = '{9'h0C0, 9'h1C1};
        release_rst();
        repeat (10) run_cycle();
        check("t2_tx_count", 32'(tx_n), 32'd4);
        check("t2_byte0", 32'(tx_log[0]), 32'h0B0);
        check("t2_byte1", 32'(tx_log[1]), 32'h0B1);
        check("t2_byte2", 32'(tx_log[2]), 32'h0C0);
        check("t2_byte3", 32'(tx_log[3]), 32'h0C1);
        check("t2_owner0", 32'(own_log[0]), 32'd0);
        check("t2_owner1", 32'(own_log[1]), 32'd1);
        check("t2_third_hs_id", 32'(hs_id[2]), 32'd1);
        check("t2_frame_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);

        // 3: req1 4-byte frame with the UART ready pattern 1,0,0,1.
        do_reset();
        src1 = '{9'h0F0, 9'h0F1, 9'h0F2, 9'h1F3};
        rdy_pat = 4'b1001;
        release_rst();
        repeat (20) run_cycle();
        check("t3_tx_count", 32'(tx_n), 32'd4);
        check("t3_byte0", 32'(tx_log[0]), 32'h0F0);
        check("t3_byte1", 32'(tx_log[1]), 32'h0F1);
        check("t3_byte2", 32'(tx_log[2]), 32'h0F2);
        check("t3_byte3", 32'(tx_log[3]), 32'h0F3);
        check("t3_hs_count", 32'(hs_n), 32'd4);
        check("t3_owner", 32'(own_log[0]), 32'd1);
        check("t3_no_timeout", 32'(tout_n), 32'd0);

        // 4: req0 stalls mid-frame; timeout releases it and req1 gets the bus.
        do_reset();
        src0 = '{9'h0D0};
        src1 = '{9'h1E0};
        release_rst();
        repeat (16) run_cycle();
        check("t4_timeout_pulses", 32'(tout_n), 32'd1);
        check("t4_timeout_delay", 32'(tout_cyc - drop_cyc), 32'd8);
        check("t4_owner0", 32'(own_log[0]), 32'd0);
        check("t4_owner1", 32'(own_log[1]), 32'd1);
        check("t4_regrant_cyc", 32'(own_cyc[1] - tout_cyc), 32'd1);
        check("t4_byte0", 32'(tx_log[0]), 32'h0D0);
        check("t4_byte1", 32'(tx_log[1]), 32'h0E0);

        // 5: reset after byte 2 of a 5-byte frame; pointer must restart at req0.
        do_reset();
        src0 = '{9'h1C0, 9'h051, 9'h052, 9'h053, 9'h054, 9'h155};
        release_rst();
        for (int i = 0; i < 40 && hs_n < 3; i++) run_cycle();
        check("t5_reached_byte2", 32'(hs_n >= 3), 32'd1);
        check("t5_mid_grant", 32'(a_grant), 32'd1);
        check("t5_mid_tx_data", 32'(a_tx_data), 32'h52);
        do_reset();
        src0 = '{9'h1E7};
        src1 = '{9'h1E8};
        release_rst();
        repeat (8) run_cycle();
        check("t5_owner0", 32'(own_log[0]), 32'd0);
        check("t5_owner1", 32'(own_log[1]), 32'd1);
        check("t5_byte0", 32'(tx_log[0]), 32'h0E7);
        check("t5_byte1", 32'(tx_log[1]), 32'h0E8);

        // 6: four requesters always sending single-byte frames rotate 0,1,2,3.
        do_reset();
        release_rst();
        b_valid = 4'hF;
        b_last  = 4'hF;
        b_data  = 32'h33221100;
        for (int i = 0; i < 16; i++) begin
            bseq[i] = -1;
            bbytes[i] = -1;
        end
        nb = 0; nby = 0; b_prev = '0;
        #1;
        repeat (20) begin
            if (b_grant != 4'h0 && b_grant != b_prev && nb < 16) begin
                for (int k = 0; k < 4; k++) if (b_grant[k]) bseq[nb] = k;
                nb++;
            end
            if (b_tx_valid && b_uart_ready && nby < 16) begin
                bbytes[nby] = int'(b_tx_data);
                nby++;
            end
            b_prev = b_grant;
            @(posedge clk);
            #3;
        end
        for (int i = 0; i < 8; i++) check("t6_grant_seq", 32'(bseq[i]), 32'(i % 4));
        for (int i = 0; i < 4; i++) check("t6_byte_seq", 32'(bbytes[i]), 32'(i * 17));

        // 6b: with the timeout disabled a silent owner keeps its grant indefinitely.
        do_reset();
        release_rst();
        b_valid = 4'b0001;
        b_last  = 4'b0000;
        b_data  = 32'h000000AB;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        b_valid = 4'b0000;
        b_touts = 0;
        repeat (30) begin
            @(posedge clk);
            #3;
            if (b_tout) b_touts++;
        end
        check("t6b_grant_held", 32'(b_grant), 32'd1);
        check("t6b_ready", 32'(b_ready), 32'd1);
        check("t6b_busy", 32'(b_busy), 32'd1);
        check("t6b_no_timeout", 32'(b_touts), 32'd0);
        check("t6b_last_data", 32'(b_tx_data), 32'hAB);
        check("t6b_tx_drained", 32'(b_tx_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
